// File: rtl/adpll_csr.sv
// CPU control/status register bank for the ADPLL core: shadow/active config with atomic
// commit, self-timed soft reset, lock deglitch, sticky W1C status, lock-timeout watchdog, irq.
module adpll_csr #(
    parameter int unsigned     ADDR_W    = 4,
    parameter int unsigned     FCWW      = 26,
    parameter logic [FCWW-1:0] FCW_RST   = 26'h2620000,
    parameter int unsigned     LOCK_FILT = 8,
    parameter int unsigned     RST_PULSE = 4,
    parameter int unsigned     TO_W      = 16,
    parameter logic [31:0]     VERSION   = 32'h0002_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       wdata,
    input  logic              wstrb,
    output logic [31:0]       rdata,
    output logic              ready,
    input  logic              channel_lock,
    input  logic              channel_sat,
    output logic              rst_core,
    output logic              irq,
    output logic [FCWW-1:0]   fcw,
    output logic [1:0]        adpll_mode,
    output logic              en,
    output logic [19:0]       cfg_gain,
    output logic [11:0]       cfg_iir,
    output logic [4:0]        fcw_mod,
    output logic [23:0]       dco_test,
    output logic [9:0]        pd_test
);

    localparam int unsigned LF_W = $clog2(LOCK_FILT + 1);
    localparam int unsigned PC_W = $clog2(RST_PULSE + 1);
    localparam logic [LF_W-1:0] LF_MAX     = LF_W'(LOCK_FILT);
    localparam logic [PC_W-1:0] PULSE_LOAD = PC_W'(RST_PULSE - 1);

    localparam logic [ADDR_W-1:0] A_SOFT_RST = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_COMMIT   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_FCW      = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_MODE_EN  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_GAIN     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_IIR      = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] A_FCW_MOD  = ADDR_W'(6);
    localparam logic [ADDR_W-1:0] A_DCO_TEST = ADDR_W'(7);
    localparam logic [ADDR_W-1:0] A_PD_TEST  = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(9);
    localparam logic [ADDR_W-1:0] A_IRQ_MASK = ADDR_W'(10);
    localparam logic [ADDR_W-1:0] A_TIMEOUT  = ADDR_W'(11);
    localparam logic [ADDR_W-1:0] A_VERSION  = ADDR_W'(12);

    typedef struct packed {
        logic [FCWW-1:0] fcw;
        logic [1:0]      mode;
        logic            en;
        logic [19:0]     gain;
        logic [11:0]     iir;
        logic [4:0]      fcw_mod;
        logic [23:0]     dco;
        logic [9:0]      pd;
    } cfg_t;

    localparam cfg_t CFG_RST = '{fcw: FCW_RST, mode: 2'd0, en: 1'b0, gain: 20'h0478E,
                                 iir: 12'hB22, fcw_mod: 5'b01001, dco: 24'h0, pd: 10'h247};

    // Reserved zero bits inside the packed test/IIR words stay zero regardless of writes.
    localparam logic [11:0] IIR_MASK = 12'hF77;
    localparam logic [23:0] DCO_MASK = 24'hFFFF1F;
    localparam logic [9:0]  PD_MASK  = 10'h377;

    cfg_t              shadow_q, shadow_d, active_q, active_d;
    logic              auto_q, auto_d;
    logic [3:0]        mask_q, mask_d;
    logic [TO_W-1:0]   to_lim_q, to_lim_d, to_cnt_q, to_cnt_d;
    logic [3:0]        sticky_q, sticky_d, sticky_set, sticky_clr;
    logic [LF_W-1:0]   lf_cnt_q, lf_cnt_d;
    logic              lock_prev_q, sat_q, lock_filt, to_set;
    logic [PC_W-1:0]   pulse_cnt_q;
    logic              rst_core_q, irq_q, ready_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              wr, rd_req, soft_rst, commit;

    assign wr       = valid & wstrb;
    assign rd_req   = valid & ~wstrb;
    assign soft_rst = wr && (address == A_SOFT_RST) && wdata[0];

    assign lock_filt = (lf_cnt_q == LF_MAX) && !rst_core_q;

    // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        auto_d   = auto_q;
        mask_d   = mask_q;
        to_lim_d = to_lim_q;
        commit   = 1'b0;
        if (wr) begin
            case (address)
                A_COMMIT: begin
                    auto_d = wdata[1];
                    commit = wdata[0];
                end
                A_FCW: begin
                    shadow_d.fcw = wdata[FCWW-1:0];
                    if (auto_q) active_d.fcw = wdata[FCWW-1:0];
                end
                A_MODE_EN: begin
                    shadow_d.mode = wdata[1:0];
                    shadow_d.en   = wdata[2];
                    if (auto_q) begin
                        active_d.mode = wdata[1:0];
                        active_d.en   = wdata[2];
                    end
                end
                A_GAIN: begin
                    shadow_d.gain = wdata[19:0];
                    if (auto_q) active_d.gain = wdata[19:0];
                end
                A_IIR: begin
                    shadow_d.iir = wdata[11:0] & IIR_MASK;
                    if (auto_q) active_d.iir = wdata[11:0] & IIR_MASK;
                end
                A_FCW_MOD: begin
                    shadow_d.fcw_mod = wdata[4:0];
                    if (auto_q) active_d.fcw_mod = wdata[4:0];
                end
                A_DCO_TEST: begin
                    shadow_d.dco = wdata[23:0] & DCO_MASK;
                    if (auto_q) active_d.dco = wdata[23:0] & DCO_MASK;
                end
                A_PD_TEST: begin
                    shadow_d.pd = wdata[9:0] & PD_MASK;
                    if (auto_q) active_d.pd = wdata[9:0] & PD_MASK;
                end
                A_IRQ_MASK: mask_d   = wdata[11:8];
                A_TIMEOUT:  to_lim_d = wdata[TO_W-1:0];
                default: ;
            endcase
        end
        if (commit) active_d = shadow_q;
    end

    always_comb begin
        lf_cnt_d = lf_cnt_q;
        if (!channel_lock)        lf_cnt_d = '0;
        else if (lf_cnt_q != LF_MAX) lf_cnt_d = lf_cnt_q + LF_W'(1);

        to_cnt_d = to_cnt_q;
        if (!active_q.en || lock_filt) to_cnt_d = '0;
        else if (to_cnt_q != to_lim_q)  to_cnt_d = to_cnt_q + TO_W'(1);
        to_set = active_q.en && !lock_filt && (to_lim_q != '0) && (to_cnt_d == to_lim_q);

        // Sticky order: {timeout, sat_seen, lock_loss, lock_acq}; a set beats a same-cycle clear.
        sticky_set = {to_set, channel_sat, lock_prev_q & ~lock_filt, lock_filt & ~lock_prev_q};
        sticky_clr = (wr && (address == A_STATUS)) ? wdata[11:8] : 4'b0;
        sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            A_COMMIT:   rdata_d = {30'b0, auto_q, 1'b0};
            A_FCW:      rdata_d = 32'(shadow_q.fcw);
            A_MODE_EN:  rdata_d = {29'b0, shadow_q.en, shadow_q.mode};
            A_GAIN:     rdata_d = 32'(shadow_q.gain);
            A_IIR:      rdata_d = 32'(shadow_q.iir);
            A_FCW_MOD:  rdata_d = 32'(shadow_q.fcw_mod);
            A_DCO_TEST: rdata_d = 32'(shadow_q.dco);
            A_PD_TEST:  rdata_d = 32'(shadow_q.pd);
            A_STATUS:   rdata_d = {20'b0, sticky_q, 6'b0, sat_q, lock_filt};
            A_IRQ_MASK: rdata_d = {20'b0, mask_q, 8'b0};
            A_TIMEOUT:  rdata_d = 32'(to_lim_q);
            A_VERSION:  rdata_d = VERSION;
            default:    rdata_d = '0;
        endcase
    end

    // The bus handshake ignores soft reset so requests during the rst_core pulse still complete.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= valid;
            rdata_q <= rd_req ? rdata_d : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || soft_rst) begin
            shadow_q    <= CFG_RST;
            active_q    <= CFG_RST;
            auto_q      <= 1'b0;
            mask_q      <= '0;
            to_lim_q    <= '0;
            to_cnt_q    <= '0;
            sticky_q    <= '0;
            lf_cnt_q    <= '0;
            lock_prev_q <= 1'b0;
            sat_q       <= 1'b0;
            irq_q       <= 1'b0;
            rst_core_q  <= 1'b1;
            pulse_cnt_q <= PULSE_LOAD;
        end else begin
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            auto_q      <= auto_d;
            mask_q      <= mask_d;
            to_lim_q    <= to_lim_d;
            to_cnt_q    <= to_cnt_d;
            sticky_q    <= sticky_d;
            lf_cnt_q    <= lf_cnt_d;
            lock_prev_q <= lock_filt;
            sat_q       <= channel_sat;
            irq_q       <= |(sticky_q & mask_q);
            if (pulse_cnt_q != '0) pulse_cnt_q <= pulse_cnt_q - PC_W'(1);
            else                   rst_core_q  <= 1'b0;
        end
    end

    assign rdata      = rdata_q;
    assign ready      = ready_q;
    assign rst_core   = rst_core_q;
    assign irq        = irq_q;
    assign fcw        = active_q.fcw;
    assign adpll_mode = active_q.mode;
    assign en         = active_q.en;
    assign cfg_gain   = active_q.gain;
    assign cfg_iir    = active_q.iir;
    assign fcw_mod    = active_q.fcw_mod;
    assign dco_test   = active_q.dco;
    assign pd_test    = active_q.pd;

endmodule

// File: tb/tb_adpll_csr.sv
// Directed self-checking bench for adpll_csr; inputs change and outputs are sampled 1 ns after posedge.
module tb_adpll_csr;

    logic        clk = 1'b0;
    logic        rst, valid, wstrb, channel_lock, channel_sat;
    logic [3:0]  address;
    logic [31:0] wdata, rdata, d;
    logic        ready, rst_core, irq, en;
    logic [25:0] fcw;
    logic [1:0]  adpll_mode;
    logic [19:0] cfg_gain;
    logic [11:0] cfg_iir;
    logic [4:0]  fcw_mod;
    logic [23:0] dco_test;
    logic [9:0]  pd_test;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adpll_csr dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready), .channel_lock(channel_lock), .channel_sat(channel_sat),
        .rst_core(rst_core), .irq(irq), .fcw(fcw), .adpll_mode(adpll_mode), .en(en),
        .cfg_gain(cfg_gain), .cfg_iir(cfg_iir), .fcw_mod(fcw_mod), .dco_test(dco_test),
        .pd_test(pd_test)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        valid = 1'b1; wstrb = 1'b1; address = a; wdata = v;
        tick();
        valid = 1'b0; wstrb = 1'b0; wdata = '0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        valid = 1'b1; wstrb = 1'b0; address = a;
        tick();
        valid = 1'b0;
        check("rd_ready", 32'(ready), 32'h1);
        v = rdata;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; wstrb = 1'b0; address = '0; wdata = '0;
        channel_lock = 1'b0; channel_sat = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_core_after_rst", 32'(rst_core), 32'h1);
        repeat (4) tick();
        check("rst_core_idle", 32'(rst_core), 32'h0);
        check("irq_rst", 32'(irq), 32'h0);
        check("ready_idle", 32'(ready), 32'h0);
        check("fcw_rst", 32'(fcw), 32'h0262_0000);
        check("gain_rst", 32'(cfg_gain), 32'h0478E);
        check("iir_rst", 32'(cfg_iir), 32'hB22);
        check("fcw_mod_rst", 32'(fcw_mod), 32'h09);
        check("dco_rst", 32'(dco_test), 32'h0);
        check("pd_rst", 32'(pd_test), 32'h247);
        check("en_mode_rst", {29'b0, en, adpll_mode}, 32'h0);
        rd(4'd2, d);  check("rd_fcw_rst", d, 32'h0262_0000);
        rd(4'd4, d);  check("rd_gain_rst", d, 32'h0004_78E);
        rd(4'd8, d);  check("rd_pd_rst", d, 32'h247);
        rd(4'd12, d); check("rd_version", d, 32'h0002_0000);
        tick();
        check("ready_drops", 32'(ready), 32'h0);

        // Shadow write then explicit commit
        wr(4'd2, 32'h0264_0000);
        check("fcw_before_commit", 32'(fcw), 32'h0262_0000);
        rd(4'd2, d);  check("rd_fcw_shadow", d, 32'h0264_0000);
        wr(4'd1, 32'h1);
        check("fcw_after_commit", 32'(fcw), 32'h0264_0000);
        rd(4'd1, d);  check("rd_commit", d, 32'h0);

        // Auto commit on, then off again
        wr(4'd1, 32'h2);
        wr(4'd6, 32'h1F);
        check("fcw_mod_auto", 32'(fcw_mod), 32'h1F);
        rd(4'd1, d);  check("rd_auto", d, 32'h2);
        wr(4'd1, 32'h0);
        wr(4'd6, 32'h03);
        check("fcw_mod_held", 32'(fcw_mod), 32'h1F);
        rd(4'd6, d);  check("rd_fcw_mod_shadow", d, 32'h03);

        // Lock filter: 7 cycles is too short, 8 cycles locks
        channel_lock = 1'b1;
        repeat (7) tick();
        channel_lock = 1'b0;
        rd(4'd9, d);  check("status_lock7", d, 32'h0);
        rd(4'd9, d);  check("status_lock7_after", d, 32'h0);
        channel_lock = 1'b1;
        repeat (8) tick();
        wr(4'd10, 32'h100);
        check("irq_not_yet", 32'(irq), 32'h0);
        tick();
        check("irq_lock_acq", 32'(irq), 32'h1);
        rd(4'd9, d);  check("status_lock8", d, 32'h101);
        wr(4'd9, 32'h100);
        tick();
        check("irq_cleared", 32'(irq), 32'h0);
        rd(4'd9, d);  check("status_acq_cleared", d, 32'h001);

        // Lock loss event coincides with a W1C of lock_loss
        channel_lock = 1'b0;
        tick();
        wr(4'd9, 32'h200);
        rd(4'd9, d);  check("status_loss_wins", d, 32'h200);

        // Saturation: live bit and sticky bit
        channel_sat = 1'b1;
        tick();
        channel_sat = 1'b0;
        rd(4'd9, d);  check("status_sat", d, 32'h602);
        wr(4'd9, 32'h600);
        rd(4'd9, d);  check("status_clear", d, 32'h0);

        // Watchdog: timeout exactly 100 cycles after en rises
        wr(4'd11, 32'd100);
        wr(4'd3, 32'h4);
        wr(4'd1, 32'h1);
        check("en_committed", 32'(en), 32'h1);
        repeat (99) tick();
        rd(4'd9, d);  check("timeout_cycle99", d, 32'h0);
        rd(4'd9, d);  check("timeout_cycle100", d, 32'h800);

        // Watchdog with lock acquired around cycle 50: no timeout
        wr(4'd3, 32'h0);
        wr(4'd1, 32'h1);
        wr(4'd9, 32'h800);
        rd(4'd9, d);  check("timeout_cleared", d, 32'h0);
        wr(4'd3, 32'h4);
        wr(4'd1, 32'h1);
        repeat (41) tick();
        channel_lock = 1'b1;
        repeat (9) tick();
        repeat (60) tick();
        rd(4'd9, d);  check("no_timeout_locked", d, 32'h101);
        channel_lock = 1'b0;
        tick();

        // Soft reset restores defaults and pulses rst_core for 4 cycles
        wr(4'd2, 32'h0123_4567);
        wr(4'd4, 32'h04783);
        wr(4'd1, 32'h1);
        check("fcw_changed", 32'(fcw), 32'h0123_4567);
        check("gain_changed", 32'(cfg_gain), 32'h04783);
        wr(4'd0, 32'h1);
        check("rst_core_c1", 32'(rst_core), 32'h1);
        check("fcw_soft_rst", 32'(fcw), 32'h0262_0000);
        check("gain_soft_rst", 32'(cfg_gain), 32'h0478E);
        check("en_soft_rst", 32'(en), 32'h0);
        rd(4'd2, d);  check("rd_fcw_soft", d, 32'h0262_0000);
        check("rst_core_c2", 32'(rst_core), 32'h1);
        rd(4'd4, d);  check("rd_gain_soft", d, 32'h0478E);
        check("rst_core_c3", 32'(rst_core), 32'h1);
        tick();
        check("rst_core_c4", 32'(rst_core), 32'h1);
        tick();
        check("rst_core_end", 32'(rst_core), 32'h0);
        rd(4'd11, d); check("rd_timeout_soft", d, 32'h0);
        rd(4'd10, d); check("rd_mask_soft", d, 32'h0);
        rd(4'd0, d);  check("rd_soft_rst", d, 32'h0);

        // Unmapped address
        rd(4'd13, d); check("rd_unmapped", d, 32'h0);
        wr(4'd13, 32'hFFFF_FFFF);
        rd(4'd13, d); check("rd_unmapped_wr", d, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adpll_csr.md
Name: adpll_csr

Overview:
- Parametrised, next-generation CPU control/status register bank for the ADPLL core. Sits between the CPU bus and the ADPLL controller.
- Shadow registers with atomic commit, so FCW, mode and enable change on the same cycle.
- Registered read path.
- Self-timed soft-reset pulse generator.
- Lock deglitch filter, sticky write-1-to-clear status, lock-timeout watchdog and a maskable interrupt.

Parameters:
- ADDR_W, 4: word-address width (registers 0..12 used).
- FCWW, 26: FCW width.
- FCW_RST, 26'h2620000: FCW reset value (2440 MHz).
- LOCK_FILT, 8: consecutive channel_lock cycles required for filtered lock (>=1).
- RST_PULSE, 4: rst_core pulse length in cycles after a soft reset (>=1).
- TO_W, 16: lock-timeout counter width.
- VERSION, 32'h0002_0000: constant returned at address 12.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- valid  in  1  CPU request
- address  in  ADDR_W  word address
- wdata  in  32  write data
- wstrb  in  1  1 = write, 0 = read
- rdata  out  32  registered read data; valid while ready=1
- ready  out  1  request acknowledge
- channel_lock  in  1  raw lock from the ADPLL controller
- channel_sat  in  1  raw saturation from the ADPLL controller
- rst_core  out  1  reset to the ADPLL controller
- irq  out  1  interrupt, level
- fcw  out  FCWW  active FCW
- adpll_mode  out  2  active mode
- en  out  1  active enable
- cfg_gain  out  20  {beta, alpha_s_tx, alpha_s_rx, alpha_m, alpha_l}, 4 bits each
- cfg_iir  out  12  {iir_n_tx[11:10], iir_n_rx[9:8], 1'b0, lambda_tx[6:4], 1'b0, lambda_rx[2:0]}
- fcw_mod  out  5  modulation FCW
- dco_test  out  24  {c_s[23:16], c_m[15:8], 3'b0, c_l[4:0]}
- pd_test  out  10  {osc_gain[9:8], 1'b0, tdc_ctr_freq[6:4], 1'b0, tdc_pd_inj, tdc_pd, dco_pd}

Behaviour:
- Handshake:
  - ready <= valid each cycle, so every access completes in 1 cycle; back-to-back requests are accepted every cycle.
  - A write updates its target at the edge where valid&wstrb is sampled.
  - A read registers rdata at that edge; rdata is presented with ready.
  - Unmapped addresses read 32'h0 and ignore writes.
- Register map, word addresses, each register laid out in the same bit order as the corresponding output (all shadow unless noted):
  - 0 SOFT_RST (write bit0=1 triggers; reads 0)
  - 1 COMMIT (bit0 = commit pulse, reads 0; bit1 = auto_commit, persistent)
  - 2 FCW
  - 3 MODE_EN (mode[1:0], en bit2)
  - 4 GAIN
  - 5 IIR
  - 6 FCW_MOD
  - 7 DCO_TEST
  - 8 PD_TEST
  - 9 STATUS: live bit0 lock_filt, bit1 channel_sat (registered); sticky W1C bit8 lock_acq, bit9 lock_loss, bit10 sat_seen, bit11 timeout
  - 10 IRQ_MASK [11:8]
  - 11 TIMEOUT [TO_W-1:0]
  - 12 VERSION (read-only)
- Reads of config registers return the shadow value.
- Reset values (rst or soft reset), shadow and active alike:
  - fcw=FCW_RST, mode=0, en=0
  - alpha_l=14, alpha_m=8, alpha_s_rx=7, alpha_s_tx=4, beta=0
  - lambda_rx=2, lambda_tx=2, iir_n_rx=3, iir_n_tx=2
  - fcw_mod=5'b01001
  - dco test words 0
  - dco_pd=1, tdc_pd=1, tdc_pd_inj=1, tdc_ctr_freq=3'b100, osc_gain=2'b10
  - auto_commit=0, sticky=0, IRQ_MASK=0, TIMEOUT=0
  - rdata=0, ready=0, irq=0
- Commit:
  - Writing COMMIT with bit0=1 copies all shadow registers to active on that edge; outputs change the next cycle.
  - With auto_commit=1, each config write updates shadow and active on the same edge.
- Soft reset:
  - Writing SOFT_RST with bit0=1 restores all reset values on the next edge.
  - rst_core is held high for exactly RST_PULSE cycles, starting the cycle after the write.
  - rst asserts rst_core on the next edge and restarts the pulse counter.
  - Soft reset beats any write or commit in the same cycle.
  - The bus handshake keeps running during the pulse.
- Lock filter:
  - A counter, saturating at LOCK_FILT, increments while channel_lock=1 and clears on channel_lock=0.
  - lock_filt=1 once the count reaches LOCK_FILT, i.e. LOCK_FILT cycles after channel_lock rises. It drops the cycle after channel_lock=0.
  - lock_filt is forced to 0 while rst_core=1.
  - A rising edge of lock_filt sets lock_acq; a falling edge sets lock_loss.
  - channel_sat=1 sets sat_seen.
- Timeout watchdog:
  - Counter clears while en=0 or lock_filt=1, and increments while en=1 and lock_filt=0.
  - When the counter equals a nonzero TIMEOUT, timeout is set and the counter holds.
  - TIMEOUT=0 disables the watchdog.
- Sticky bits: a W1C write clears selected bits; a set event in the same cycle wins.
- irq <= |(sticky[11:8] & IRQ_MASK[11:8]), registered.

Test Plan:
- After rst: read FCW -> 32'h02620000; read GAIN -> 20'h0478E; pd_test -> 10'h247; rst_core=0, irq=0.
- Write FCW 26'h2640000 with auto_commit=0 -> shadow readback updated, fcw output unchanged. Write COMMIT=1 -> fcw=26'h2640000 on the cycle after the commit write.
- LOCK_FILT=8: channel_lock high for 7 cycles then low -> lock_filt stays 0. Then high for 8 cycles -> lock_filt=1, lock_acq set; with IRQ_MASK bit8 set, irq=1. Write STATUS 32'h100 -> irq clears.
- TIMEOUT=100, commit en=1, channel_lock=0 -> STATUS bit11 set exactly 100 cycles after en rises. Repeat with lock acquired at cycle 50 -> no timeout.
- Soft reset after changing FCW and alpha_l -> defaults read back, rst_core high exactly 4 cycles. Interleaved reads during the pulse get ready one cycle after valid.
- Same-cycle W1C of bit9 and a lock_filt falling edge -> bit9 stays 1. Read address 13 -> 32'h0.
